ballot_input_unit: RTL

//  Front-end ballot stage sitting directly upstream of the vote counter.

---
 rtl/vm_pkg.sv | 21 ++
 rtl/vote_debounce.sv | 54 +++++
 rtl/ballot_input_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared types and constants for the ballot front-end.
package vm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CAST_A,
        CAST_B,
        RELEASE
    } ballot_state_t;

    // Depth of the metastability synchroniser on every raw button
    localparam int SYNC_STAGES = 2;

    // Positions of the three raw inputs inside the packed input vector
    localparam int NUM_INPUTS = 3;
    localparam int IDX_ARM    = 0;
    localparam int IDX_A      = 1;
    localparam int IDX_B      = 2;

endpackage

// File: rtl/vote_debounce.sv
// Synchroniser, debouncer and rise detector for one raw push button.
// The debounced level follows the synchronised input only after
// DEBOUNCE_CYCLES consecutive samples that disagree with the current level.
// rise is a registered one-cycle pulse issued together with a 0->1 level change.
module vote_debounce
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   level_reg;
    logic                   rise_reg;
    logic                   synced;

    assign synced = sync_reg[SYNC_STAGES-1];

    // Synchronise the raw input, count disagreeing samples, commit the level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg  <= '0;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
            rise_reg <= 1'b0;
            if (synced == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                // Enough consecutive disagreeing samples: take the new level
                cnt_reg   <= '0;
                level_reg <= synced;
                rise_reg  <= synced;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/ballot_input_unit.sv
// Ballot front-end: debounces arm/A/B buttons and allows exactly one vote
// per arming, emitting single-cycle vote_a / vote_b pulses.
// Optional feature macro: BALLOT_TIMEOUT_EN (auto-disarm after TIMEOUT_CYCLES
// cycles in ARMED). Without it ARMED persists and timeout is tied low.
module ballot_input_unit
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic arm_btn,
    input  logic btn_a,
    input  logic btn_b,
    output logic vote_a,
    output logic vote_b,
    output logic ready,
    output logic busy,
    output logic reject,
    output logic timeout
);

    logic [NUM_INPUTS-1:0] raw_vec;
    logic [NUM_INPUTS-1:0] level_vec;
    logic [NUM_INPUTS-1:0] rise_vec;

    ballot_state_t state_reg;
    ballot_state_t state_next;

    logic timer_expired;
    logic arm_rise;
    logic cast_a;
    logic cast_b;
    logic ambiguous;

    assign raw_vec = {btn_b, btn_a, arm_btn};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_input
            vote_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset_n(reset_n),
                .raw    (raw_vec[gi]),
                .level  (level_vec[gi]),
                .rise   (rise_vec[gi])
            );
        end
    endgenerate

    // rise is registered together with the level update, so both agree here
    assign arm_rise  = rise_vec[IDX_ARM] & level_vec[IDX_ARM];
    // A press is valid only when the other candidate button is debounced-low;
    // simultaneous rises leave both levels high and so fall into ambiguous.
    assign cast_a    = rise_vec[IDX_A] & ~level_vec[IDX_B];
    assign cast_b    = rise_vec[IDX_B] & ~level_vec[IDX_A];
    assign ambiguous = (rise_vec[IDX_A] | rise_vec[IDX_B]) & ~cast_a & ~cast_b;

`ifdef BALLOT_TIMEOUT_EN
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] timer_reg;

    // Count ARMED cycles; held at zero elsewhere so every arming starts fresh
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_reg <= '0;
        end else if (state_reg != ARMED) begin
            timer_reg <= '0;
        end else if (timer_reg != TMR_MAX) begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    // timer_reg holds n-1 during the n-th ARMED cycle
    assign timer_expired = (timer_reg == TMR_LAST);
`else
    assign timer_expired = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_next = state_reg;
        vote_a     = 1'b0;
        vote_b     = 1'b0;
        ready      = 1'b0;
        busy       = 1'b0;
        reject     = 1'b0;
        timeout    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (arm_rise) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                ready = 1'b1;
                if (cast_a) begin
                    state_next = CAST_A;
                end else if (cast_b) begin
                    state_next = CAST_B;
                end else if (timer_expired) begin
                    // A cast in the expiry cycle takes priority (checked above)
                    timeout    = 1'b1;
                    state_next = IDLE;
                end else if (ambiguous) begin
                    reject = 1'b1;
                end
            end
            CAST_A: begin
                vote_a     = 1'b1;
                busy       = 1'b1;
                state_next = RELEASE;
            end
            CAST_B: begin
                vote_b     = 1'b1;
                busy       = 1'b1;
                state_next = RELEASE;
            end
            RELEASE: begin
                busy = 1'b1;
                if (!level_vec[IDX_A] && !level_vec[IDX_B]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
